pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, which is the PC/target width (shared constant).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, which is the number of cycles flush is held after a redirect (range 1..7).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, which is the maximum number of WAIT_MEM cycles before a fetch error (range 1..255).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port branch_req, input, 1 bit: a taken branch/jump resolved this cycle.
REQ-007 SHALL have port branch_target, input, DATA_W bits: the redirect address, valid with branch_req.
REQ-008 SHALL have port hazard_stall, input, 1 bit: a decode-stage load-use hold request.
REQ-009 SHALL have port imem_ready, input, 1 bit: the instruction memory has delivered the current fetch.
REQ-010 SHALL have port halt_req, input, 1 bit: a level-sensitive halt request.
REQ-011 SHALL have port resume, input, 1 bit: a single-cycle pulse that leaves HALT.
REQ-012 SHALL have port PCSRC, output, 1 bit: selects load of dr into the program counter.
REQ-013 SHALL have port STALL, output, 1 bit: freezes the program counter.
REQ-014 SHALL have port dr, output, DATA_W bits: the redirect address presented to the program counter.
REQ-015 SHALL have port flush, output, 1 bit: kills wrong-path instructions in fetch/decode.
REQ-016 SHALL have port fetch_err, output, 1 bit: sticky memory-timeout flag.
REQ-017 SHALL have port state, output, 2 bits: the current state (RUN=0, WAIT_MEM=1, FLUSH=2, HALT=3).

Function
REQ-018 All outputs SHALL be registered on the CLK rising edge, so the program counter (negedge-clocked) samples them half a cycle later.
REQ-019 The FSM SHALL use states RUN, WAIT_MEM, FLUSH and HALT.
REQ-020 In RUN, the next action SHALL follow this priority: halt_req, then branch_req (or a pending branch), then !imem_ready, then hazard_stall, then normal increment.
REQ-021 On halt_req in RUN: go to HALT, STALL=1, PCSRC=0.
REQ-022 On a branch in RUN: dr<=branch_target for one cycle with PCSRC=1 and STALL=0; flush=1; load the flush counter with FLUSH_CYCLES-1; go to FLUSH (FLUSH_CYCLES=1 returns to RUN next cycle); this applies even when hazard_stall=1 or imem_ready=0 in the same cycle.
REQ-023 On !imem_ready in RUN: STALL=1, clear the wait counter, go to WAIT_MEM.
REQ-024 On hazard_stall only in RUN: STALL=1 for that cycle and remain in RUN.
REQ-025 FLUSH: flush=1 and STALL=0, with the counter decrementing to 0 and then returning to RUN; branch_req and hazard_stall are ignored (wrong path); halt_req is deferred until FLUSH completes.
REQ-026 WAIT_MEM: STALL=1 and the wait counter increments each cycle; imem_ready=1 returns to RUN.
REQ-027 In WAIT_MEM, when the counter reaches MEM_TIMEOUT with imem_ready=0: set fetch_err=1 and go to HALT.
REQ-028 A branch_req arriving in WAIT_MEM SHALL be latched as pending (target held; a later branch_req overwrites it) and applied on the first RUN cycle.
REQ-029 HALT: STALL=1, PCSRC=0, flush=0; resume=1 with halt_req=0 goes to RUN and clears fetch_err; resume while halt_req=1 is ignored.
REQ-030 PCSRC and STALL SHALL never both be 1.
REQ-031 dr SHALL hold its last value when PCSRC=0.
REQ-032 The counters SHALL saturate and never wrap.

Reset
REQ-033 RST=1 SHALL asynchronously force state=RUN, PCSRC=0, STALL=0, flush=0, fetch_err=0, dr=0, all counters cleared and the pending branch cleared.
REQ-034 Reset asserted mid-FLUSH or mid-WAIT_MEM SHALL abandon the operation with no residual flush or pending branch.
REQ-035 After reset is released, the first rising edge SHALL evaluate RUN priority normally.

Structure
REQ-036 DATA_W and the four state encodings SHALL live in the shared definitions include file.
REQ-037 The flush and wait counters SHALL be one sub-module, seq_counter (load, decrement/increment, saturate, zero/limit flag), instantiated twice.
REQ-038 No combinational path SHALL exist from an input to an output.

Verification
REQ-039 Reset release, imem_ready=1, all else 0: STALL=0, PCSRC=0, state=RUN for 10 cycles.
REQ-040 branch_req=1 with target 0x00A0 in RUN: next cycle PCSRC=1, dr=0x00A0, flush=1 for 2 cycles, then RUN; a second branch_req during FLUSH is ignored.
REQ-041 imem_ready=0 for 3 cycles with branch_req to 0x0040 in cycle 2: STALL=1 for 3 cycles, then PCSRC=1 with dr=0x0040.
REQ-042 imem_ready held 0: after 15 WAIT_MEM cycles fetch_err=1 and state=HALT; a resume pulse gives RUN with fetch_err=0.
REQ-043 branch_req and hazard_stall together: PCSRC=1, STALL=0; hazard_stall alone: STALL=1 for exactly its duration.
REQ-044 RST pulsed during FLUSH: flush=0 and state=RUN immediately, asynchronous to CLK.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
//==============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared definitions for the PC sequencer. Holds the default
//               PC/target width, the FSM state encodings and the widths of
//               the internal flush and wait counters.
// Revision    : 1.0 - initial release
//==============================================================================
package pc_sequencer_pkg;

  // Default program-counter / branch-target width
  localparam int DATA_W = 16;

  // State encodings, also presented on the state output
  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_WAIT_MEM = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

  // Counter widths cover the full legal parameter ranges
  // (FLUSH_CYCLES 1..7, MEM_TIMEOUT 1..255)
  localparam int FLUSH_CNT_W = 3;
  localparam int WAIT_CNT_W  = 8;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_seq_counter.sv
`default_nettype none
//==============================================================================
// Module      : seq_counter
// Description : Small saturating counter with synchronous clear and load.
//               UP=1 counts up and stops at LIMIT; UP=0 counts down and stops
//               at zero. The single done flag reports count==LIMIT when
//               counting up and count==0 when counting down.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset (count -> 0)
//               clr      - synchronous clear (highest priority)
//               load     - synchronous load of load_val (clamped to LIMIT)
//               load_val - value for load
//               step     - advance one count in the configured direction
//               done     - limit (UP=1) or zero (UP=0) reached
// Revision    : 1.0 - initial release
//==============================================================================
module seq_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255,
  parameter bit UP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic             done
);

  localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= (load_val > C_LIMIT) ? C_LIMIT : load_val;
    end else if (step) begin
      // Saturate at the end of travel instead of wrapping
      if (UP) begin
        if (r_count != C_LIMIT) r_count <= r_count + 1'b1;
      end else begin
        if (r_count != '0) r_count <= r_count - 1'b1;
      end
    end
  end

  assign done = UP ? (r_count == C_LIMIT) : (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencing FSM. Decides each cycle whether the
//               PC increments, stalls, or loads a redirect address, and drives
//               the wrong-path flush and the fetch-timeout error flag. Every
//               output is registered on the rising edge so a negedge-clocked
//               PC samples stable values half a cycle later.
// Ports       : CLK           - clock, rising edge
//               RST           - asynchronous active-high reset
//               branch_req    - taken branch/jump this cycle
//               branch_target - redirect address, valid with branch_req
//               hazard_stall  - decode load-use hold request
//               imem_ready    - instruction memory delivered current fetch
//               halt_req      - level-sensitive halt request
//               resume        - pulse that leaves HALT
//               PCSRC         - load dr into the PC
//               STALL         - freeze the PC
//               dr            - redirect address (holds when PCSRC=0)
//               flush         - kill wrong-path fetch/decode instructions
//               fetch_err     - sticky memory-timeout flag
//               state         - current FSM state
// Revision    : 1.0 - initial release
//==============================================================================
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int DATA_W       = pc_sequencer_pkg::DATA_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              branch_req,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              hazard_stall,
  input  logic              imem_ready,
  input  logic              halt_req,
  input  logic              resume,
  output logic              PCSRC,
  output logic              STALL,
  output logic [DATA_W-1:0] dr,
  output logic              flush,
  output logic              fetch_err,
  output logic [1:0]        state
);

  localparam logic [FLUSH_CNT_W-1:0] C_FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_pcsrc;
  logic              r_stall;
  logic              r_flush;
  logic              r_fetch_err;
  logic              r_pend;
  logic [DATA_W-1:0] r_dr;
  logic [DATA_W-1:0] r_pend_tgt;

  logic              w_pcsrc_nxt;
  logic              w_stall_nxt;
  logic              w_flush_nxt;
  logic              w_err_nxt;
  logic              w_pend_nxt;
  logic [DATA_W-1:0] w_dr_nxt;
  logic [DATA_W-1:0] w_pend_tgt_nxt;

  logic              w_branch_avail;
  logic [DATA_W-1:0] w_branch_tgt;
  logic              w_take_branch;
  logic              w_resume_ok;
  logic              w_wait_clr;
  logic              w_flush_done;
  logic              w_wait_done;

  // A fresh branch overrides an older pending one
  assign w_branch_avail = branch_req | r_pend;
  assign w_branch_tgt   = branch_req ? branch_target : r_pend_tgt;
  assign w_resume_ok    = resume & ~halt_req;

  // A branch is taken from RUN, or straight out of WAIT_MEM as memory returns
  // so the held redirect is issued without an extra idle cycle. Halt wins.
  assign w_take_branch = ~halt_req & w_branch_avail &
                         ((r_state == S_RUN) | ((r_state == S_WAIT_MEM) & imem_ready));

  assign w_wait_clr = (r_state == S_RUN) & ~halt_req & ~w_branch_avail & ~imem_ready;

  // Flush counter: loaded on redirect, counts down through FLUSH
  seq_counter #(
    .WIDTH (FLUSH_CNT_W),
    .LIMIT (FLUSH_CYCLES - 1),
    .UP    (1'b0)
  ) u_flush_cnt (
    .clk      (CLK),
    .rst      (RST),
    .clr      (1'b0),
    .load     (w_take_branch),
    .load_val (C_FLUSH_LOAD),
    .step     (r_state == S_FLUSH),
    .done     (w_flush_done)
  );

  // Wait counter: cleared on entry to WAIT_MEM, counts WAIT_MEM cycles.
  // The limit is MEM_TIMEOUT-1 because the entry cycle holds count 0, so
  // done marks the last permitted WAIT_MEM cycle.
  seq_counter #(
    .WIDTH (WAIT_CNT_W),
    .LIMIT (MEM_TIMEOUT - 1),
    .UP    (1'b1)
  ) u_wait_cnt (
    .clk      (CLK),
    .rst      (RST),
    .clr      (w_wait_clr),
    .load     (1'b0),
    .load_val ('0),
    .step     (r_state == S_WAIT_MEM),
    .done     (w_wait_done)
  );

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_RUN;
      r_pcsrc     <= 1'b0;
      r_stall     <= 1'b0;
      r_flush     <= 1'b0;
      r_fetch_err <= 1'b0;
      r_dr        <= '0;
      r_pend      <= 1'b0;
      r_pend_tgt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pcsrc     <= w_pcsrc_nxt;
      r_stall     <= w_stall_nxt;
      r_flush     <= w_flush_nxt;
      r_fetch_err <= w_err_nxt;
      r_dr        <= w_dr_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_tgt  <= w_pend_tgt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (halt_req)            w_state_nxt = S_HALT;
        else if (w_branch_avail) w_state_nxt = S_FLUSH;
        else if (!imem_ready)    w_state_nxt = S_WAIT_MEM;
        else                     w_state_nxt = S_RUN;
      end
      S_WAIT_MEM: begin
        if (imem_ready)       w_state_nxt = w_take_branch ? S_FLUSH : S_RUN;
        else if (w_wait_done) w_state_nxt = S_HALT;
        else                  w_state_nxt = S_WAIT_MEM;
      end
      S_FLUSH: begin
        // Halt requests wait until the wrong-path window has closed
        if (w_flush_done) w_state_nxt = S_RUN;
      end
      S_HALT: begin
        if (w_resume_ok) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Output logic (values registered at the next rising edge)
  always_comb begin
    w_pcsrc_nxt    = w_take_branch;
    w_dr_nxt       = w_take_branch ? w_branch_tgt : r_dr;
    w_flush_nxt    = w_take_branch | ((r_state == S_FLUSH) & ~w_flush_done);
    w_stall_nxt    = 1'b0;
    w_err_nxt      = r_fetch_err;
    w_pend_nxt     = r_pend;
    w_pend_tgt_nxt = r_pend_tgt;

    case (r_state)
      S_RUN: begin
        w_stall_nxt = halt_req | (~w_branch_avail & (~imem_ready | hazard_stall));
      end
      S_WAIT_MEM: begin
        w_stall_nxt = ~imem_ready;
        if (!imem_ready && w_wait_done) w_err_nxt = 1'b1;
      end
      S_FLUSH: begin
        w_stall_nxt = 1'b0;
      end
      S_HALT: begin
        w_stall_nxt = ~w_resume_ok;
        if (w_resume_ok) w_err_nxt = 1'b0;
      end
      default: w_stall_nxt = 1'b0;
    endcase

    if (w_take_branch) begin
      w_pend_nxt = 1'b0;
    end else if ((r_state == S_WAIT_MEM) && branch_req) begin
      w_pend_nxt     = 1'b1;
      w_pend_tgt_nxt = branch_target;
    end
  end

  assign PCSRC     = r_pcsrc;
  assign STALL     = r_stall;
  assign dr        = r_dr;
  assign flush     = r_flush;
  assign fetch_err = r_fetch_err;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. A table of directed
//               vectors with hand-computed outputs is applied cycle by cycle,
//               followed by hand-written asynchronous reset sequences.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pc_sequencer;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] FLSH = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        branch_req;
  logic [15:0] branch_target;
  logic        hazard_stall;
  logic        imem_ready;
  logic        halt_req;
  logic        resume;
  logic        PCSRC;
  logic        STALL;
  logic [15:0] dr;
  logic        flush;
  logic        fetch_err;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic        br;
    logic [15:0] tgt;
    logic        hz;
    logic        rdy;
    logic        halt;
    logic        res;
    logic        e_pcsrc;
    logic        e_stall;
    logic        e_flush;
    logic        e_err;
    logic [1:0]  e_state;
    logic [15:0] e_dr;
  } vec_t;

  vec_t vecs[$];

  pc_sequencer #(
    .DATA_W       (16),
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (15)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .hazard_stall  (hazard_stall),
    .imem_ready    (imem_ready),
    .halt_req      (halt_req),
    .resume        (resume),
    .PCSRC         (PCSRC),
    .STALL         (STALL),
    .dr            (dr),
    .flush         (flush),
    .fetch_err     (fetch_err),
    .state         (state)
  );

  always #5 CLK = ~CLK;

  function automatic void add(input string name, input logic br, input logic [15:0] tgt,
                              input logic hz, input logic rdy, input logic halt, input logic res,
                              input logic p, input logic s, input logic f, input logic e,
                              input logic [1:0] st, input logic [15:0] d);
    vec_t v;
    v.name = name; v.br = br; v.tgt = tgt; v.hz = hz; v.rdy = rdy; v.halt = halt; v.res = res;
    v.e_pcsrc = p; v.e_stall = s; v.e_flush = f; v.e_err = e; v.e_state = st; v.e_dr = d;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic p, input logic s, input logic f,
                       input logic e, input logic [1:0] st, input logic [15:0] d);
    n_checks++;
    if ({PCSRC, STALL, flush, fetch_err, state, dr} !== {p, s, f, e, st, d}) begin
      n_errors++;
      $display("FAIL %s: got pcsrc=%0b stall=%0b flush=%0b err=%0b state=%0d dr=%h, expected pcsrc=%0b stall=%0b flush=%0b err=%0b state=%0d dr=%h",
               name, PCSRC, STALL, flush, fetch_err, state, dr, p, s, f, e, st, d);
    end
  endtask

  task automatic idle_inputs();
    branch_req = 1'b0; branch_target = 16'h0; hazard_stall = 1'b0;
    imem_ready = 1'b1; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();

    // ---------------- vector table ----------------
    for (int k = 0; k < 10; k++)
      add($sformatf("idle_run_%0d", k), 0, 16'h0, 0, 1, 0, 0,  0, 0, 0, 0, RUN, 16'h0000);
    add("branch_a0",          1, 16'h00A0, 0, 1, 0, 0,  1, 0, 1, 0, FLSH, 16'h00A0);
    add("branch_in_flush",    1, 16'h0BAD, 0, 1, 0, 0,  0, 0, 1, 0, FLSH, 16'h00A0);
    add("flush_done",         0, 16'h0,    0, 1, 0, 0,  0, 0, 0, 0, RUN,  16'h00A0);
    add("branch_and_hazard",  1, 16'h0100, 1, 1, 0, 0,  1, 0, 1, 0, FLSH, 16'h0100);
    add("hazard_in_flush",    0, 16'h0,    1, 1, 0, 0,  0, 0, 1, 0, FLSH, 16'h0100);
    add("back_to_run",        0, 16'h0,    0, 1, 0, 0,  0, 0, 0, 0, RUN,  16'h0100);
    add("hazard_1",           0, 16'h0,    1, 1, 0, 0,  0, 1, 0, 0, RUN,  16'h0100);
    add("hazard_2",           0, 16'h0,    1, 1, 0, 0,  0, 1, 0, 0, RUN,  16'h0100);
    add("hazard_end",         0, 16'h0,    0, 1, 0, 0,  0, 0, 0, 0, RUN,  16'h0100);
    add("mem_wait_1",         0, 16'h0,    0, 0, 0, 0,  0, 1, 0, 0, WAIT, 16'h0100);
    add("mem_wait_branch",    1, 16'h0040, 0, 0, 0, 0,  0, 1, 0, 0, WAIT, 16'h0100);
    add("mem_wait_3",         0, 16'h0,    0, 0, 0, 0,  0, 1, 0, 0, WAIT, 16'h0100);
    add("pending_applied",    0, 16'h0,    0, 1, 0, 0,  1, 0, 1, 0, FLSH, 16'h0040);
    add("pending_flush_2",    0, 16'h0,    0, 1, 0, 0,  0, 0, 1, 0, FLSH, 16'h0040);
    add("pending_run",        0, 16'h0,    0, 1, 0, 0,  0, 0, 0, 0, RUN,  16'h0040);
    add("halt_enter",         0, 16'h0,    0, 1, 1, 0,  0, 1, 0, 0, HALT, 16'h0040);
    add("resume_while_halt",  0, 16'h0,    0, 1, 1, 1,  0, 1, 0, 0, HALT, 16'h0040);
    add("halt_hold",          0, 16'h0,    0, 1, 0, 0,  0, 1, 0, 0, HALT, 16'h0040);
    add("halt_resume",        0, 16'h0,    0, 1, 0, 1,  0, 0, 0, 0, RUN,  16'h0040);
    add("branch_200",         1, 16'h0200, 0, 1, 0, 0,  1, 0, 1, 0, FLSH, 16'h0200);
    add("halt_deferred_1",    0, 16'h0,    0, 1, 1, 0,  0, 0, 1, 0, FLSH, 16'h0200);
    add("halt_deferred_2",    0, 16'h0,    0, 1, 1, 0,  0, 0, 0, 0, RUN,  16'h0200);
    add("halt_after_flush",   0, 16'h0,    0, 1, 1, 0,  0, 1, 0, 0, HALT, 16'h0200);
    add("resume_2",           0, 16'h0,    0, 1, 0, 1,  0, 0, 0, 0, RUN,  16'h0200);
    for (int k = 0; k < 15; k++)
      add($sformatf("timeout_wait_%0d", k), 0, 16'h0, 0, 0, 0, 0,  0, 1, 0, 0, WAIT, 16'h0200);
    add("timeout_halt",       0, 16'h0,    0, 0, 0, 0,  0, 1, 0, 1, HALT, 16'h0200);
    add("err_sticky",         0, 16'h0,    0, 1, 0, 0,  0, 1, 0, 1, HALT, 16'h0200);
    add("err_resume",         0, 16'h0,    0, 1, 0, 1,  0, 0, 0, 0, RUN,  16'h0200);

    // ---------------- reset state ----------------
    #1;
    check("reset_async", 0, 0, 0, 0, RUN, 16'h0000);
    #11;
    RST = 1'b0;

    // ---------------- table application ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      branch_req    = vecs[i].br;
      branch_target = vecs[i].tgt;
      hazard_stall  = vecs[i].hz;
      imem_ready    = vecs[i].rdy;
      halt_req      = vecs[i].halt;
      resume        = vecs[i].res;
      step();
      check(vecs[i].name, vecs[i].e_pcsrc, vecs[i].e_stall, vecs[i].e_flush,
            vecs[i].e_err, vecs[i].e_state, vecs[i].e_dr);
    end
    idle_inputs();

    // ---------------- reset during FLUSH ----------------
    branch_req = 1'b1; branch_target = 16'h0AAA;
    step();
    check("rst_flush_pre", 1, 0, 1, 0, FLSH, 16'h0AAA);
    idle_inputs();
    #3 RST = 1'b1;
    #1 check("rst_flush_async", 0, 0, 0, 0, RUN, 16'h0000);
    #2 RST = 1'b0;
    step();
    check("rst_flush_after", 0, 0, 0, 0, RUN, 16'h0000);

    // ---------------- reset during WAIT_MEM with pending branch ----------------
    imem_ready = 1'b0;
    step();
    check("rst_wait_enter", 0, 1, 0, 0, WAIT, 16'h0000);
    branch_req = 1'b1; branch_target = 16'h0300;
    step();
    check("rst_wait_pending", 0, 1, 0, 0, WAIT, 16'h0000);
    branch_req = 1'b0;
    #3 RST = 1'b1;
    #1 check("rst_wait_async", 0, 0, 0, 0, RUN, 16'h0000);
    #2 RST = 1'b0;
    imem_ready = 1'b1;
    step();
    check("rst_wait_no_pending_1", 0, 0, 0, 0, RUN, 16'h0000);
    step();
    check("rst_wait_no_pending_2", 0, 0, 0, 0, RUN, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
